mem_port_arbiter: RTL and testbench

- Shares the single byte-addressable data memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Registered two-stage pipeline: arbitrate/latch request, then drive memory and capture the read result; one-cycle response pulse per requester.
- Fixed priority to D with an anti-starvation counter for I.
- Sits between the fetch/memory stages and the memory model; memory read is combinational, write commits on posedge clk.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_arb.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

   typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_e;
   typedef enum logic {PORT_I, PORT_D} port_e;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic                  we;
      logic [1:0]            size;
      logic                  unsigned_load;
   } mem_req_t;

   function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
      return (value >= limit) ? limit : value + 4'd1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int AWIDTH = ADDR_WIDTH,
   parameter int DWIDTH = DATA_WIDTH
);
   logic              i_req_valid_i;
   logic              i_req_ready_o;
   logic [AWIDTH-1:0] i_addr_i;
   logic              i_rsp_valid_o;
   logic [DWIDTH-1:0] i_rsp_data_o;

   logic              d_req_valid_i;
   logic              d_req_ready_o;
   logic [AWIDTH-1:0] d_addr_i;
   logic [DWIDTH-1:0] d_wdata_i;
   logic              d_we_i;
   logic [1:0]        d_size_i;
   logic              d_unsigned_i;
   logic              d_rsp_valid_o;
   logic [DWIDTH-1:0] d_rsp_data_o;

   logic [AWIDTH-1:0] mem_addr_o;
   logic [DWIDTH-1:0] mem_data_o;
   logic              mem_read_en_o;
   logic              mem_write_en_o;
   logic [1:0]        mem_size_o;
   logic              mem_unsigned_o;
   logic [DWIDTH-1:0] mem_data_i;

   modport slave (
      input  i_req_valid_i, i_addr_i,
      output i_req_ready_o, i_rsp_valid_o, i_rsp_data_o,
      input  d_req_valid_i, d_addr_i, d_wdata_i, d_we_i, d_size_i, d_unsigned_i,
      output d_req_ready_o, d_rsp_valid_o, d_rsp_data_o,
      output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_size_o, mem_unsigned_o,
      input  mem_data_i
   );

   modport master (
      output i_req_valid_i, i_addr_i,
      input  i_req_ready_o, i_rsp_valid_o, i_rsp_data_o,
      output d_req_valid_i, d_addr_i, d_wdata_i, d_we_i, d_size_i, d_unsigned_i,
      input  d_req_ready_o, d_rsp_valid_o, d_rsp_data_o,
      input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_size_o, mem_unsigned_o,
      output mem_data_i
   );

endinterface

// File: rtl/mem_port_arbiter_arb.sv
// Grant select for the shared memory port: D has priority, I wins after STARVE_LIMIT consecutive losses.
module arb_priority_starve
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic i_valid_i,
   input  logic d_valid_i,
   output logic grant_i_o,
   output logic grant_d_o
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt_q;
   logic [3:0] starve_cnt_d;
   logic       i_starved;

   assign i_starved = i_valid_i && (starve_cnt_q == LIMIT);

   always_comb begin
      grant_i_o    = 1'b0;
      grant_d_o    = 1'b0;
      starve_cnt_d = '0;
      if (d_valid_i && !i_starved) begin
         grant_d_o = 1'b1;
      end else if (i_valid_i) begin
         grant_i_o = 1'b1;
      end
      // Only a true conflict lost by I counts; anything else resets the streak.
      if (i_valid_i && grant_d_o) begin
         starve_cnt_d = sat_inc(starve_cnt_q, LIMIT);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-stage arbiter sharing one memory port between fetch (I) and load/store (D).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AWIDTH       = ADDR_WIDTH,
   parameter int DWIDTH       = DATA_WIDTH,
   parameter int STARVE_LIMIT = 4
)(
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam logic [0:0] ST_IDLE   = ARB_IDLE;
   localparam logic [0:0] ST_ACCESS = ARB_ACCESS;

   logic [0:0]        state_q, state_d;
   port_e             port_q, port_d;
   mem_req_t          req_q, req_d;
   logic              i_rsp_valid_q, i_rsp_valid_d;
   logic [DWIDTH-1:0] i_rsp_data_q, i_rsp_data_d;
   logic              d_rsp_valid_q, d_rsp_valid_d;
   logic [DWIDTH-1:0] d_rsp_data_q, d_rsp_data_d;

   logic i_valid, d_valid, grant_i, grant_d;

   // Masking with rst keeps both ready outputs low while reset is held.
   assign i_valid = bus.i_req_valid_i & rst;
   assign d_valid = bus.d_req_valid_i & rst;

   arb_priority_starve #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_valid_i (i_valid),
      .d_valid_i (d_valid),
      .grant_i_o (grant_i),
      .grant_d_o (grant_d)
   );

   assign bus.i_req_ready_o = grant_i;
   assign bus.d_req_ready_o = grant_d;

   always_comb begin
      state_d = ST_IDLE;
      port_d  = port_q;
      req_d   = req_q;
      if (grant_d) begin
         state_d             = ST_ACCESS;
         port_d              = PORT_D;
         req_d.addr          = ADDR_WIDTH'(bus.d_addr_i);
         req_d.wdata         = DATA_WIDTH'(bus.d_wdata_i);
         req_d.we            = bus.d_we_i;
         req_d.size          = bus.d_size_i;
         req_d.unsigned_load = bus.d_unsigned_i;
      end else if (grant_i) begin
         state_d             = ST_ACCESS;
         port_d              = PORT_I;
         req_d.addr          = ADDR_WIDTH'(bus.i_addr_i);
         req_d.wdata         = '0;
         req_d.we            = 1'b0;
         req_d.size          = MEM_SIZE_WORD;
         req_d.unsigned_load = 1'b0;
      end
   end

   always_comb begin
      i_rsp_valid_d = 1'b0;
      i_rsp_data_d  = i_rsp_data_q;
      d_rsp_valid_d = 1'b0;
      d_rsp_data_d  = d_rsp_data_q;
      if (state_q == ST_ACCESS) begin
         if (port_q == PORT_I) begin
            i_rsp_valid_d = 1'b1;
            i_rsp_data_d  = bus.mem_data_i;
         end else begin
            d_rsp_valid_d = 1'b1;
            d_rsp_data_d  = req_q.we ? '0 : bus.mem_data_i;
         end
      end
   end

   // Memory is driven only while the holding register is full.
   always_comb begin
      bus.mem_addr_o     = '0;
      bus.mem_data_o     = '0;
      bus.mem_read_en_o  = 1'b0;
      bus.mem_write_en_o = 1'b0;
      bus.mem_size_o     = '0;
      bus.mem_unsigned_o = 1'b0;
      if (state_q == ST_ACCESS) begin
         bus.mem_addr_o     = AWIDTH'(req_q.addr);
         bus.mem_data_o     = DWIDTH'(req_q.wdata);
         bus.mem_read_en_o  = ~req_q.we;
         bus.mem_write_en_o = req_q.we;
         bus.mem_size_o     = req_q.size;
         bus.mem_unsigned_o = req_q.unsigned_load;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         port_q        <= PORT_I;
         req_q         <= '0;
         i_rsp_valid_q <= 1'b0;
         i_rsp_data_q  <= '0;
         d_rsp_valid_q <= 1'b0;
         d_rsp_data_q  <= '0;
      end else begin
         state_q       <= state_d;
         port_q        <= port_d;
         req_q         <= req_d;
         i_rsp_valid_q <= i_rsp_valid_d;
         i_rsp_data_q  <= i_rsp_data_d;
         d_rsp_valid_q <= d_rsp_valid_d;
         d_rsp_data_q  <= d_rsp_data_d;
      end
   end

   assign bus.i_rsp_valid_o = i_rsp_valid_q;
   assign bus.i_rsp_data_o  = i_rsp_data_q;
   assign bus.d_rsp_valid_o = d_rsp_valid_q;
   assign bus.d_rsp_data_o  = d_rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter with a byte-addressed memory model and response scoreboard.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

   mem_port_arbiter #(
      .AWIDTH       (32),
      .DWIDTH       (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem_b [256];
   logic [7:0] ref_b [256];
   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];

   function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz, input logic uns);
      case (sz)
         2'b00:   return uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
         2'b01:   return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Memory model: combinational read with extension, write on posedge.
   logic [7:0] ra;
   always_comb begin
      ra = bus.mem_addr_o[7:0];
      bus.mem_data_i = extend({mem_b[ra + 8'd3], mem_b[ra + 8'd2], mem_b[ra + 8'd1], mem_b[ra]},
                              bus.mem_size_o, bus.mem_unsigned_o);
   end

   initial begin
      forever begin
         @(posedge clk);
         if (bus.mem_write_en_o) begin
            mem_b[bus.mem_addr_o[7:0]] = bus.mem_data_o[7:0];
            if (bus.mem_size_o != 2'b00) mem_b[bus.mem_addr_o[7:0] + 8'd1] = bus.mem_data_o[15:8];
            if (bus.mem_size_o == 2'b10) begin
               mem_b[bus.mem_addr_o[7:0] + 8'd2] = bus.mem_data_o[23:16];
               mem_b[bus.mem_addr_o[7:0] + 8'd3] = bus.mem_data_o[31:24];
            end
         end
      end
   end

   task automatic ref_access(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                             input logic [1:0] sz, input logic uns, output logic [31:0] res);
      logic [7:0] a;
      a = addr[7:0];
      res = 32'h0;
      if (we) begin
         ref_b[a] = wdata[7:0];
         if (sz != 2'b00) ref_b[a + 8'd1] = wdata[15:8];
         if (sz == 2'b10) begin
            ref_b[a + 8'd2] = wdata[23:16];
            ref_b[a + 8'd3] = wdata[31:24];
         end
      end else begin
         res = extend({ref_b[a + 8'd3], ref_b[a + 8'd2], ref_b[a + 8'd1], ref_b[a]}, sz, uns);
      end
   endtask

   // Accept monitor: samples just before the rising edge and queues the expected response.
   exp_t        acc_e;
   logic [31:0] acc_val;
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (rst && bus.d_req_valid_i && bus.d_req_ready_o) begin
            ref_access(bus.d_addr_i, bus.d_wdata_i, bus.d_we_i, bus.d_size_i, bus.d_unsigned_i, acc_val);
            acc_e.is_d = 1'b1; acc_e.data = acc_val; acc_e.cyc = cyc;
            exp_q.push_back(acc_e);
         end else if (rst && bus.i_req_valid_i && bus.i_req_ready_o) begin
            ref_access(bus.i_addr_i, 32'h0, 1'b0, 2'b10, 1'b0, acc_val);
            acc_e.is_d = 1'b0; acc_e.data = acc_val; acc_e.cyc = cyc;
            exp_q.push_back(acc_e);
         end
         cyc = cyc + 1;
      end
   end

   // Response scoreboard.
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (rst && (bus.i_rsp_valid_o || bus.d_rsp_valid_o)) begin
            checks++;
            if (bus.i_rsp_valid_o && bus.d_rsp_valid_o) begin
               errors++;
               $display("FAIL rsp_both_ports: got i_rsp_valid=1 d_rsp_valid=1, required at most one");
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got i=%0b d=%0b at cyc %0d, required no response",
                        bus.i_rsp_valid_o, bus.d_rsp_valid_o, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               if (bus.d_rsp_valid_o !== mon_e.is_d ||
                   (mon_e.is_d ? bus.d_rsp_data_o : bus.i_rsp_data_o) !== mon_e.data ||
                   cyc != mon_e.cyc + 2) begin
                  errors++;
                  $display("FAIL rsp_scoreboard: got port_d=%0b data=%h cyc=%0d, required port_d=%0b data=%h cyc=%0d",
                           bus.d_rsp_valid_o, mon_e.is_d ? bus.d_rsp_data_o : bus.i_rsp_data_o, cyc,
                           mon_e.is_d, mon_e.data, mon_e.cyc + 2);
               end else begin
                  $display("rsp port=%s data=%h cyc=%0d", mon_e.is_d ? "D" : "I", mon_e.data, cyc);
               end
            end
         end
      end
   end

   task automatic idle_inputs();
      bus.i_req_valid_i = 1'b0; bus.i_addr_i = 32'h0;
      bus.d_req_valid_i = 1'b0; bus.d_addr_i = 32'h0; bus.d_wdata_i = 32'h0;
      bus.d_we_i = 1'b0; bus.d_size_i = 2'b00; bus.d_unsigned_i = 1'b0;
   endtask

   task automatic drive_d(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                          input logic [1:0] sz, input logic uns);
      bus.d_req_valid_i = 1'b1; bus.d_addr_i = addr; bus.d_wdata_i = wdata;
      bus.d_we_i = we; bus.d_size_i = sz; bus.d_unsigned_i = uns;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.i_req_valid_i = 1'b1; bus.i_addr_i = 32'h0100_0000;
      drive_d(32'h0100_0000, 32'h0, 1'b0, 2'b10, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({bus.i_req_ready_o, bus.d_req_ready_o} !== 2'b00) begin
         errors++; $display("FAIL reset_ready: got %b, required 00", {bus.i_req_ready_o, bus.d_req_ready_o});
      end
      checks++;
      if ({bus.mem_write_en_o, bus.mem_read_en_o, bus.i_rsp_valid_o, bus.d_rsp_valid_o} !== 4'b0000) begin
         errors++; $display("FAIL reset_outputs: got we/re/irsp/drsp=%b, required 0000",
                            {bus.mem_write_en_o, bus.mem_read_en_o, bus.i_rsp_valid_o, bus.d_rsp_valid_o});
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.i_req_ready_o, bus.d_req_ready_o} !== 2'b01) begin
         errors++; $display("FAIL reset_release_grant: got i/d ready=%b, required 01",
                            {bus.i_req_ready_o, bus.d_req_ready_o});
      end
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single_fetch();
      @(negedge clk);
      bus.i_req_valid_i = 1'b1; bus.i_addr_i = 32'h0100_0000;
      #1;
      checks++;
      if (bus.i_req_ready_o !== 1'b1) begin
         errors++; $display("FAIL fetch_ready: got %b, required 1", bus.i_req_ready_o);
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if (bus.mem_read_en_o !== 1'b1 || bus.mem_size_o !== 2'b10 || bus.mem_addr_o !== 32'h0100_0000) begin
         errors++; $display("FAIL fetch_mem_drive: got re=%b size=%b addr=%h, required 1 10 01000000",
                            bus.mem_read_en_o, bus.mem_size_o, bus.mem_addr_o);
      end
      @(negedge clk);
      checks++;
      if (bus.i_rsp_valid_o !== 1'b1 || bus.i_rsp_data_o !== 32'h0000_0093 || bus.d_rsp_valid_o !== 1'b0) begin
         errors++; $display("FAIL fetch_rsp: got valid=%b data=%h d_valid=%b, required 1 00000093 0",
                            bus.i_rsp_valid_o, bus.i_rsp_data_o, bus.d_rsp_valid_o);
      end
      @(negedge clk);
      checks++;
      if (bus.i_rsp_valid_o !== 1'b0 || bus.mem_read_en_o !== 1'b0) begin
         errors++; $display("FAIL fetch_pulse_end: got rsp_valid=%b re=%b, required 0 0",
                            bus.i_rsp_valid_o, bus.mem_read_en_o);
      end
   endtask

   task automatic test_store_load();
      @(negedge clk);
      drive_d(32'h0100_0010, 32'hFFFF_FF80, 1'b1, 2'b00, 1'b0);
      @(negedge clk);
      drive_d(32'h0100_0010, 32'h0, 1'b0, 2'b00, 1'b0);
      @(negedge clk);
      drive_d(32'h0100_0010, 32'h0, 1'b0, 2'b00, 1'b1);
      checks++;
      if (bus.d_rsp_valid_o !== 1'b1 || bus.d_rsp_data_o !== 32'h0) begin
         errors++; $display("FAIL store_rsp: got valid=%b data=%h, required 1 00000000",
                            bus.d_rsp_valid_o, bus.d_rsp_data_o);
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if (bus.d_rsp_data_o !== 32'hFFFF_FF80) begin
         errors++; $display("FAIL lb_rsp: got %h, required ffffff80", bus.d_rsp_data_o);
      end
      @(negedge clk);
      checks++;
      if (bus.d_rsp_data_o !== 32'h0000_0080) begin
         errors++; $display("FAIL lbu_rsp: got %h, required 00000080", bus.d_rsp_data_o);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_contention();
      logic [9:0] exp_i_grant;
      exp_i_grant = 10'b10000_10000;
      @(negedge clk);
      bus.i_req_valid_i = 1'b1; bus.i_addr_i = 32'h0100_0000;
      drive_d(32'h0100_0010, 32'h0, 1'b0, 2'b00, 1'b1);
      for (int j = 0; j < 10; j++) begin
         if (j > 0) @(negedge clk);
         #1;
         checks++;
         if ({bus.i_req_ready_o, bus.d_req_ready_o} !== {exp_i_grant[j], ~exp_i_grant[j]}) begin
            errors++; $display("FAIL contention_grant[%0d]: got i/d ready=%b, required %b",
                               j, {bus.i_req_ready_o, bus.d_req_ready_o}, {exp_i_grant[j], ~exp_i_grant[j]});
         end
      end
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      drive_d(32'h0100_0020, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b0);
      @(negedge clk);
      idle_inputs();
      checks++;
      if (bus.mem_write_en_o !== 1'b1) begin
         errors++; $display("FAIL midrst_access: got write_en=%b, required 1", bus.mem_write_en_o);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.mem_write_en_o !== 1'b0) begin
         errors++; $display("FAIL midrst_we_drop: got write_en=%b, required 0", bus.mem_write_en_o);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_b[8'h23], mem_b[8'h22], mem_b[8'h21], mem_b[8'h20]} !== 32'h1122_3344 ||
          bus.d_rsp_valid_o !== 1'b0) begin
         errors++; $display("FAIL midrst_mem: got word=%h rsp_valid=%b, required 11223344 0",
                            {mem_b[8'h23], mem_b[8'h22], mem_b[8'h21], mem_b[8'h20]}, bus.d_rsp_valid_o);
      end
      exp_q.delete();
      ref_b[8'h20] = 8'h44; ref_b[8'h21] = 8'h33; ref_b[8'h22] = 8'h22; ref_b[8'h23] = 8'h11;
      rst = 1'b1;
      @(negedge clk);
      drive_d(32'h0100_0020, 32'h0, 1'b0, 2'b10, 1'b0);
      #1;
      checks++;
      if (bus.d_req_ready_o !== 1'b1) begin
         errors++; $display("FAIL midrst_restart_ready: got %b, required 1", bus.d_req_ready_o);
      end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.d_rsp_valid_o !== 1'b1 || bus.d_rsp_data_o !== 32'h1122_3344) begin
         errors++; $display("FAIL midrst_restart_rsp: got valid=%b data=%h, required 1 11223344",
                            bus.d_rsp_valid_o, bus.d_rsp_data_o);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bit exp_v;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         exp_v = (j >= 2) && (j <= 9);
         checks++;
         if (bus.d_rsp_valid_o !== exp_v) begin
            errors++; $display("FAIL b2b_rsp_valid[%0d]: got %b, required %b", j, bus.d_rsp_valid_o, exp_v);
         end
         if (j < 8) begin
            drive_d(32'h0100_0040 + 32'(4 * j), 32'h0, 1'b0, 2'b10, 1'b0);
            #1;
            checks++;
            if (bus.d_req_ready_o !== 1'b1) begin
               errors++; $display("FAIL b2b_ready[%0d]: got %b, required 1", j, bus.d_req_ready_o);
            end
         end else begin
            idle_inputs();
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_b[i] = 8'(i * 37 + 11);
         ref_b[i] = 8'(i * 37 + 11);
      end
      {mem_b[3], mem_b[2], mem_b[1], mem_b[0]} = 32'h0000_0093;
      {ref_b[3], ref_b[2], ref_b[1], ref_b[0]} = 32'h0000_0093;
      {mem_b[8'h23], mem_b[8'h22], mem_b[8'h21], mem_b[8'h20]} = 32'h1122_3344;
      {ref_b[8'h23], ref_b[8'h22], ref_b[8'h21], ref_b[8'h20]} = 32'h1122_3344;
      idle_inputs();

      test_reset();
      test_single_fetch();
      test_store_load();
      test_contention();
      test_reset_mid();
      test_back_to_back();

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
